// File: rtl/button_event_ctrl.sv
// Per-button PRESS/RELEASE/LONG/REPEAT event generator, round-robin scheduler and FWFT event FIFO.
// Define BTN_REPEAT_EN to enable periodic REPEAT events while a button is held.
module button_event_ctrl #(
  parameter int NUM_BUTTONS   = 4,
  parameter int ID_BITS       = 2,
  parameter int CNT_BITS      = 20,
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [ID_BITS-1:0]     evt_id,
  output logic [1:0]             evt_code,
  output logic                   ovf,
  input  logic                   ovf_clr
);
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int ENT_BITS = ID_BITS + 2;
`ifdef BTN_REPEAT_EN
  localparam logic REPEAT_EN = 1'b1;
`else
  localparam logic REPEAT_EN = 1'b0;
`endif
  localparam logic [1:0] C_PRESS   = 2'd0;
  localparam logic [1:0] C_RELEASE = 2'd1;
  localparam logic [1:0] C_LONG    = 2'd2;
  localparam logic [1:0] C_REPEAT  = 2'd3;
  localparam logic [3:0] PEND_MASK = {REPEAT_EN, 3'b111};

  typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, HELD = 2'd2} state_t;

  state_t                 state     [NUM_BUTTONS];
  state_t                 state_nxt [NUM_BUTTONS];
  logic [CNT_BITS-1:0]    cnt       [NUM_BUTTONS];
  logic [CNT_BITS-1:0]    cnt_nxt   [NUM_BUTTONS];
  logic [3:0]             pend      [NUM_BUTTONS];
  logic [3:0]             pend_set  [NUM_BUTTONS];
  logic [3:0]             pend_clr  [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] btn_prev, rise, fall, collide;
  logic [ID_BITS-1:0]     rr_ptr, sel_id;
  logic [1:0]             sel_code;
  logic                   sel_found, push, pop, full;
  logic [ENT_BITS-1:0]    mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr, rd_ptr;
  logic [PTR_BITS:0]      count;

  // Within one button, PRESS > LONG > REPEAT > RELEASE.
  function automatic logic [1:0] pick_code(input logic [3:0] p);
    if (p[C_PRESS])       pick_code = C_PRESS;
    else if (p[C_LONG])   pick_code = C_LONG;
    else if (p[C_REPEAT]) pick_code = C_REPEAT;
    else                  pick_code = C_RELEASE;
  endfunction

  assign rise = btn_in & ~btn_prev;
  assign fall = ~btn_in & btn_prev;

  always_ff @(posedge clk) begin
    btn_prev <= btn_in;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (reset) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end else begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          if (rise[i]) begin
            state_nxt[i] = PRESSED;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt[i];
          end
        end
        PRESSED: begin
          if (fall[i]) begin
            state_nxt[i] = IDLE;
          end else if (cnt[i] == CNT_BITS'(LONG_CYCLES - 1)) begin
            state_nxt[i] = HELD;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_BITS'(1);
          end
        end
        HELD: begin
          // Without repeat support the hold counter simply stays at zero.
          if (fall[i]) begin
            state_nxt[i] = IDLE;
          end else if (!REPEAT_EN || (cnt[i] == CNT_BITS'(REPEAT_CYCLES - 1))) begin
            cnt_nxt[i] = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_BITS'(1);
          end
        end
        default: begin
          state_nxt[i] = IDLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      pend_set[i] = 4'b0000;
      case (state[i])
        IDLE:    pend_set[i][C_PRESS] = rise[i];
        PRESSED: begin
          if (fall[i])                                        pend_set[i][C_RELEASE] = 1'b1;
          else if (cnt[i] == CNT_BITS'(LONG_CYCLES - 1))      pend_set[i][C_LONG]    = 1'b1;
          else                                                pend_set[i]            = 4'b0000;
        end
        HELD: begin
          if (fall[i])                                        pend_set[i][C_RELEASE] = 1'b1;
          else if (REPEAT_EN && (cnt[i] == CNT_BITS'(REPEAT_CYCLES - 1)))
                                                              pend_set[i][C_REPEAT]  = 1'b1;
          else                                                pend_set[i]            = 4'b0000;
        end
        default: pend_set[i] = 4'b0000;
      endcase
    end
  end

  // Round-robin pick: first pending button at or above rr_ptr, then wrap to the bottom.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_code  = C_PRESS;
    for (int j = 0; j < NUM_BUTTONS; j++) begin
      if (!sel_found && (j >= int'(rr_ptr)) && (pend[j] != 4'b0000)) begin
        sel_found = 1'b1;
        sel_id    = ID_BITS'(j);
        sel_code  = pick_code(pend[j]);
      end else begin
        sel_found = sel_found;
      end
    end
    for (int j = 0; j < NUM_BUTTONS; j++) begin
      if (!sel_found && (j < int'(rr_ptr)) && (pend[j] != 4'b0000)) begin
        sel_found = 1'b1;
        sel_id    = ID_BITS'(j);
        sel_code  = pick_code(pend[j]);
      end else begin
        sel_found = sel_found;
      end
    end
  end

  assign full = (count == (PTR_BITS + 1)'(FIFO_DEPTH));
  assign pop  = evt_valid & evt_ready;
  assign push = sel_found & (~full | pop);

  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      pend_clr[i] = 4'b0000;
      if (push && (sel_id == ID_BITS'(i))) pend_clr[i][sel_code] = 1'b1;
      else                                 pend_clr[i] = 4'b0000;
      collide[i] = |(pend_set[i] & pend[i] & ~pend_clr[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (reset) pend[i] <= 4'b0000;
      else       pend[i] <= ((pend[i] & ~pend_clr[i]) | pend_set[i]) & PEND_MASK;
    end
  end

  // Scheduler pointer and sticky overflow flag (a new drop beats a clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) rr_ptr <= (int'(sel_id) == NUM_BUTTONS - 1) ? '0 : sel_id + ID_BITS'(1);
      if (|collide)     ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {sel_id, sel_code};
        wr_ptr      <= wr_ptr + PTR_BITS'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_BITS + 1)'(1);
        2'b01:   count <= count - (PTR_BITS + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign evt_valid          = (count != '0);
  assign {evt_id, evt_code} = mem[rd_ptr];
endmodule
